// File: rtl/sys_periph_pkg.sv
// Register map, control/status bit positions and the bus address decoder
// shared by sys_periph and its testbench.
package sys_periph_pkg;

  localparam logic [4:0] OFF_ID      = 5'h00;
  localparam logic [4:0] OFF_SCRATCH = 5'h04;
  localparam logic [4:0] OFF_TCNT    = 5'h08;
  localparam logic [4:0] OFF_TCTRL   = 5'h0C;
  localparam logic [4:0] OFF_TCMP    = 5'h10;
  localparam logic [4:0] OFF_TXDATA  = 5'h14;
  localparam logic [4:0] OFF_TXSTAT  = 5'h18;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_FLAG = 2;

  localparam int TXSTAT_CNT_W = 5;
  localparam int TXSTAT_FULL  = 5;
  localparam int TXSTAT_EMPTY = 6;
  localparam int TXSTAT_OVF   = 7;

  typedef enum logic [2:0] {
    REG_ID,
    REG_SCRATCH,
    REG_TCNT,
    REG_TCTRL,
    REG_TCMP,
    REG_TXDATA,
    REG_TXSTAT,
    REG_NONE
  } reg_sel_e;

  // Only word-aligned addresses inside the 32-byte window select a register.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[31:5] == '0 && addr[1:0] == 2'b00) begin
      case (addr[4:0])
        OFF_ID:      sel = REG_ID;
        OFF_SCRATCH: sel = REG_SCRATCH;
        OFF_TCNT:    sel = REG_TCNT;
        OFF_TCTRL:   sel = REG_TCTRL;
        OFF_TCMP:    sel = REG_TCMP;
        OFF_TXDATA:  sel = REG_TXDATA;
        OFF_TXSTAT:  sel = REG_TXSTAT;
        default:     sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head reads as zero while empty so the output is defined out of reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/sys_periph.sv
// Memory-mapped system peripheral: ID, scratch, compare timer with interrupt,
// and a byte-wide TX FIFO, answering the CPU's sys_* bus one cycle late.
module sys_periph
  import sys_periph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] ID_VALUE   = 32'h43505533
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sys_r_addr,
  input  logic        sys_read,
  output logic [31:0] sys_r_line,
  input  logic [31:0] sys_w_addr,
  input  logic [31:0] sys_w_line,
  input  logic        sys_write,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e    rsel, wsel;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] r_line_q, r_line_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata;
  logic [7:0]  txstat;
  logic        timer_hit, push, pop, overflow;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign rsel = sys_read  ? decode_addr(sys_r_addr) : REG_NONE;
  assign wsel = sys_write ? decode_addr(sys_w_addr) : REG_NONE;

  // TX stream: tx_data is offered while tx_valid is high and a byte is
  // consumed only on a cycle where tx_valid && tx_ready; the head holds otherwise.
  assign tx_valid  = ~fifo_empty;
  assign pop       = tx_valid & tx_ready;
  assign push      = (wsel == REG_TXDATA);
  assign overflow  = push & fifo_full & ~pop;
  assign timer_hit = ctrl_q[CTRL_EN] & (cnt_q == cmp_q);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (sys_w_line[7:0]),
    .pop_i   (pop),
    .data_o  (tx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    txstat                       = '0;
    txstat[TXSTAT_CNT_W-1:0]     = TXSTAT_CNT_W'(fifo_count);
    txstat[TXSTAT_FULL]          = fifo_full;
    txstat[TXSTAT_EMPTY]         = fifo_empty;
    txstat[TXSTAT_OVF]           = ovf_q;
  end

  // Reads sample pre-edge register values, so same-cycle writes are not visible.
  always_comb begin
    rdata = '0;
    case (rsel)
      REG_ID:      rdata = ID_VALUE;
      REG_SCRATCH: rdata = scratch_q;
      REG_TCNT:    rdata = cnt_q;
      REG_TCTRL:   rdata = {29'd0, ctrl_q};
      REG_TCMP:    rdata = cmp_q;
      REG_TXSTAT:  rdata = {24'd0, txstat};
      default:     rdata = '0;
    endcase
    r_line_d = sys_read ? rdata : r_line_q;
  end

  always_comb begin
    scratch_d = scratch_q;
    cmp_d     = cmp_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    ovf_d     = ovf_q;

    if (wsel == REG_SCRATCH) scratch_d = sys_w_line;
    if (wsel == REG_TCMP)    cmp_d     = sys_w_line;

    if (wsel == REG_TCNT) begin
      cnt_d = sys_w_line;
    end else if (ctrl_q[CTRL_EN]) begin
      cnt_d = (timer_hit && ctrl_q[CTRL_AR]) ? 32'd0 : cnt_q + 32'd1;
    end

    if (wsel == REG_TCTRL) begin
      ctrl_d[CTRL_EN]   = sys_w_line[CTRL_EN];
      ctrl_d[CTRL_AR]   = sys_w_line[CTRL_AR];
      ctrl_d[CTRL_FLAG] = ctrl_q[CTRL_FLAG] & ~sys_w_line[CTRL_FLAG];
    end
    // A compare hit wins over a simultaneous write-one-to-clear.
    if (timer_hit) ctrl_d[CTRL_FLAG] = 1'b1;

    if (overflow)                ovf_d = 1'b1;
    else if (rsel == REG_TXSTAT) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scratch_q <= '0;
      cnt_q     <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
      r_line_q  <= '0;
    end else begin
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      r_line_q  <= r_line_d;
    end
  end

  assign sys_r_line = r_line_q;
  assign irq        = ctrl_q[CTRL_FLAG];

endmodule

// File: tb/tb_sys_periph.sv
// Bench for sys_periph: directed vector table, multi-cycle corner sequences
// and randomized bus traffic compared against a queue-based reference model.
module tb_sys_periph;

  localparam int          DEPTH = 8;
  localparam logic [31:0] ID    = 32'h43505533;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sys_r_addr, sys_w_addr, sys_w_line, sys_r_line;
  logic        sys_read, sys_write;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, irq;

  sys_periph #(.FIFO_DEPTH(DEPTH), .ID_VALUE(ID)) dut (
    .clk        (clk),
    .rst        (rst),
    .sys_r_addr (sys_r_addr),
    .sys_read   (sys_read),
    .sys_r_line (sys_r_line),
    .sys_w_addr (sys_w_addr),
    .sys_w_line (sys_w_line),
    .sys_write  (sys_write),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .irq        (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_scratch, m_cnt, m_cmp, m_rline;
  logic        m_en, m_ar, m_flag, m_ovf;
  logic [7:0]  m_q[$];

  task automatic model_reset();
    m_scratch = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_rline = 0;
    m_en = 0; m_ar = 0; m_flag = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // Register number 0..7 for a mapped word address, -1 otherwise.
  function automatic int m_reg(input logic [31:0] a);
    if (a > 32'h1F || a[1:0] != 2'b00) return -1;
    return int'(a >> 2);
  endfunction

  function automatic logic [31:0] m_txstat();
    int n = m_q.size();
    return {24'd0, m_ovf, 1'(n == 0), 1'(n == DEPTH), 5'(n)};
  endfunction

  task automatic model_step(input logic rd, input logic [31:0] ra, input logic wr,
                            input logic [31:0] wa, input logic [31:0] wd, input logic rdy);
    int          r, w;
    logic        hit, pop, ofl;
    logic [31:0] cnt_n;
    r   = rd ? m_reg(ra) : -1;
    w   = wr ? m_reg(wa) : -1;
    hit = m_en && (m_cnt == m_cmp);
    pop = (m_q.size() > 0) && rdy;
    ofl = (w == 5) && (m_q.size() == DEPTH) && !pop;
    if (rd) begin
      case (r)
        0:       m_rline = ID;
        1:       m_rline = m_scratch;
        2:       m_rline = m_cnt;
        3:       m_rline = {29'd0, m_flag, m_ar, m_en};
        4:       m_rline = m_cmp;
        6:       m_rline = m_txstat();
        default: m_rline = 0;
      endcase
    end
    if (w == 2)      cnt_n = wd;
    else if (m_en)   cnt_n = (hit && m_ar) ? 32'd0 : m_cnt + 32'd1;
    else             cnt_n = m_cnt;
    m_cnt = cnt_n;
    if (hit)         m_flag = 1'b1;
    else if (w == 3) m_flag = m_flag && !wd[2];
    if (w == 3) begin m_en = wd[0]; m_ar = wd[1]; end
    if (w == 1) m_scratch = wd;
    if (w == 4) m_cmp = wd;
    if (pop) void'(m_q.pop_front());
    if (w == 5 && !ofl) m_q.push_back(wd[7:0]);
    if (ofl)         m_ovf = 1'b1;
    else if (r == 6) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    check("r_line",   sys_r_line, m_rline);
    check("tx_valid", {31'd0, tx_valid}, {31'd0, 1'(m_q.size() > 0)});
    check("tx_data",  {24'd0, tx_data}, (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0);
    check("irq",      {31'd0, irq}, {31'd0, m_flag});
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic rd, input logic [31:0] ra, input logic wr,
                          input logic [31:0] wa, input logic [31:0] wd, input logic rdy);
    sys_read = rd; sys_r_addr = ra; sys_write = wr; sys_w_addr = wa;
    sys_w_line = wd; tx_ready = rdy;
    model_step(rd, ra, wr, wa, wd, rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    do_cycle(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    do_cycle(1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    do_cycle(1'b0, 32'd0, 1'b1, a, d, rdy);
  endtask

  function automatic logic [31:0] pick_addr();
    int k = $urandom_range(0, 11);
    if (k <= 6)  return 32'(k) << 2;
    if (k == 7)  return 32'h1C;
    if (k == 8)  return 32'h20 + (32'($urandom_range(0, 7)) << 2);
    if (k == 9)  return 32'h14;
    if (k == 10) return 32'h18;
    return $urandom;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rd;
    logic [31:0] ra;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic rd, input logic [31:0] ra, input logic wr,
                              input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  logic [7:0] got[$];
  int         waited;

  initial begin
    vecs[0]  = mk(1, 32'h00, 0, 32'h00, 32'h0,         ID);
    vecs[1]  = mk(1, 32'h20, 0, 32'h00, 32'h0,         32'h0);
    vecs[2]  = mk(1, 32'h1C, 0, 32'h00, 32'h0,         32'h0);
    vecs[3]  = mk(1, 32'h05, 0, 32'h00, 32'h0,         32'h0);
    vecs[4]  = mk(1, 32'h04, 1, 32'h04, 32'hDEADBEEF,  32'h0);
    vecs[5]  = mk(1, 32'h04, 0, 32'h00, 32'h0,         32'hDEADBEEF);
    vecs[6]  = mk(1, 32'h10, 1, 32'h00, 32'h12345678,  32'hFFFFFFFF);
    vecs[7]  = mk(1, 32'h00, 0, 32'h00, 32'h0,         ID);
    vecs[8]  = mk(1, 32'h0C, 0, 32'h00, 32'h0,         32'h0);
    vecs[9]  = mk(1, 32'h18, 0, 32'h00, 32'h0,         32'h40);
    vecs[10] = mk(1, 32'h04, 1, 32'h24, 32'h55,        32'hDEADBEEF);
    vecs[11] = mk(0, 32'h00, 1, 32'h06, 32'h11111111,  32'hDEADBEEF);
    vecs[12] = mk(1, 32'h04, 0, 32'h00, 32'h0,         32'hDEADBEEF);
    vecs[13] = mk(1, 32'h14, 0, 32'h00, 32'h0,         32'h0);
    vecs[14] = mk(1, 32'h18, 1, 32'h18, 32'hFF,        32'h40);

    rst = 1'b0; sys_read = 0; sys_write = 0; sys_r_addr = 0; sys_w_addr = 0;
    sys_w_line = 0; tx_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_line",   sys_r_line, 32'h0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_tx_data",  {24'd0, tx_data}, 32'h0);
    check("rst_irq",      {31'd0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);

    for (int i = 0; i < 15; i++) begin
      do_cycle(vecs[i].rd, vecs[i].ra, vecs[i].wr, vecs[i].wa, vecs[i].wd, 1'b0);
      check($sformatf("vec%0d", i), sys_r_line, vecs[i].exp);
    end

    // Timer with autoreload: CMP=5, CTRL=en|autoreload.
    wr_reg(32'h10, 32'd5, 1'b0);
    wr_reg(32'h0C, 32'd3, 1'b0);
    waited = 0;
    while (!irq && waited < 20) begin
      idle(1'b0);
      waited++;
    end
    check("irq_latency", 32'(waited), 32'd6);
    rd_reg(32'h08);
    check("cnt_after_reload", sys_r_line, 32'd0);
    rd_reg(32'h0C);
    check("ctrl_with_flag", sys_r_line, 32'd7);
    wr_reg(32'h0C, 32'd4, 1'b0);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd_reg(32'h08);
    check("cnt_frozen", sys_r_line, 32'd3);

    // Compare hit and W1C in the same cycle keeps the flag; CNT write has priority.
    wr_reg(32'h10, 32'd10, 1'b0);
    wr_reg(32'h0C, 32'd1, 1'b0);
    wr_reg(32'h08, 32'd9, 1'b0);
    idle(1'b0);
    wr_reg(32'h0C, 32'd5, 1'b0);
    check("flag_set_beats_clear", {31'd0, irq}, 32'd1);
    wr_reg(32'h0C, 32'd4, 1'b0);
    check("flag_clear", {31'd0, irq}, 32'd0);

    // FIFO fill past full, sticky overflow, then drain.
    for (int i = 0; i < 9; i++) wr_reg(32'h14, 32'(i), 1'b0);
    rd_reg(32'h18);
    check("txstat_ovf", sys_r_line, 32'hA8);
    rd_reg(32'h18);
    check("txstat_ovf_cleared", sys_r_line, 32'h28);
    got.delete();
    waited = 0;
    while (tx_valid && waited < 20) begin
      got.push_back(tx_data);
      idle(1'b1);
      waited++;
    end
    check("drain_len", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) check("drain_byte", {24'd0, got[i]}, 32'(i));

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) wr_reg(32'h14, 32'h10 + 32'(i), 1'b0);
    wr_reg(32'h14, 32'hAA, 1'b1);
    check("head_after_pushpop", {24'd0, tx_data}, 32'h11);
    rd_reg(32'h18);
    check("txstat_pushpop_full", sys_r_line, 32'h28);
    waited = 0;
    while (tx_valid && waited < 20) begin
      idle(1'b1);
      waited++;
    end
    check("drain_done", {31'd0, tx_valid}, 32'd0);

    // Reset asserted while a TXDATA write is pending.
    wr_reg(32'h14, 32'h33, 1'b0);
    sys_write = 1'b1; sys_w_addr = 32'h14; sys_w_line = 32'h77; tx_ready = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1; sys_write = 1'b0; sys_w_addr = 0; sys_w_line = 0;
    model_reset();
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_tx_data",  {24'd0, tx_data}, 32'd0);
    check("midrst_r_line",   sys_r_line, 32'd0);
    rd_reg(32'h18);
    check("midrst_txstat", sys_r_line, 32'h40);
    rd_reg(32'h04);
    check("midrst_scratch", sys_r_line, 32'd0);

    // Randomized traffic against the model.
    wr_reg(32'h10, 32'($urandom_range(3, 12)), 1'b0);
    wr_reg(32'h0C, 32'($urandom_range(1, 3)), 1'b0);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
      do_cycle(1'($urandom_range(0, 1)), pick_addr(),
               1'($urandom_range(0, 2) != 0), pick_addr(), wd,
               1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sys_periph.md
SYS_PERIPH -- requirements
Module: sys_periph

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ID_VALUE, default 32'h43505533, constant returned by the ID register.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port sys_r_addr, input, 32 bits, read byte address from the memory stage.
REQ-006 SHALL have port sys_read, input, 1 bit, read strobe, single cycle per access.
REQ-007 SHALL have port sys_r_line, output, 32 bits, read data.
REQ-008 SHALL have port sys_w_addr, input, 32 bits, write byte address.
REQ-009 SHALL have port sys_w_line, input, 32 bits, write data.
REQ-010 SHALL have port sys_write, input, 1 bit, write strobe, single cycle per access.
REQ-011 SHALL have port tx_data, output, 8 bits, head of TX FIFO.
REQ-012 SHALL have port tx_valid, output, 1 bit, FIFO non-empty.
REQ-013 SHALL have port tx_ready, input, 1 bit, consumer accept; pop when tx_valid && tx_ready.
REQ-014 SHALL have port irq, output, 1 bit, timer interrupt level, equals TIMER_CTRL.flag.

Function
REQ-015 SHALL decode addr[4:2] only when addr[31:5]==0 and addr[1:0]==0; otherwise the access is unmapped.
REQ-016 SHALL implement this register map: 0x00 ID RO; 0x04 SCRATCH RW; 0x08 TIMER_CNT RW; 0x0C TIMER_CTRL RW; 0x10 TIMER_CMP RW; 0x14 TXDATA WO; 0x18 TXSTAT RO.
REQ-017 SHALL register sys_r_line one cycle after sys_read and hold it until the next read; unmapped or WO reads return 0.
REQ-018 SHALL give reads the pre-write value when a read and a write hit the same register in the same cycle.
REQ-019 SHALL ignore writes to unmapped or RO registers, with no side effects.
REQ-020 SHALL lay out TIMER_CTRL as bit0 en, bit1 autoreload, bit2 flag (W1C), other bits reading 0.
REQ-021 SHALL increment TIMER_CNT by 1 per clk while en=1, wrapping from 0xFFFFFFFF to 0.
REQ-022 SHALL set flag on the cycle TIMER_CNT==TIMER_CMP while en=1; if autoreload=1 the next CNT is 0, else counting continues.
REQ-023 SHALL give a software CNT write priority over increment and reload that cycle.
REQ-024 SHALL keep flag set when a hardware set and a W1C clear occur in the same cycle.
REQ-025 SHALL push sys_w_line[7:0] to the FIFO on a TXDATA write; when full, drop the data and set sticky ovf.
REQ-026 SHALL accept a push while full when a pop occurs in the same cycle, and leave count unchanged.
REQ-027 SHALL lay out TXSTAT as [4:0] count, bit5 full, bit6 empty, bit7 ovf.
REQ-028 SHALL clear ovf on a TXSTAT read, unless an overflow occurs in the same cycle.
REQ-029 SHALL keep tx_data stable while tx_valid=1 and tx_ready=0.
REQ-030 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, using an extra pointer bit for full/empty.

Reset
REQ-031 SHALL reset, while rst=0, sys_r_line=0, SCRATCH=0, TIMER_CNT=0, TIMER_CTRL=0, TIMER_CMP=0xFFFFFFFF, ovf=0 and FIFO empty, giving tx_valid=0, tx_data=0 and irq=0.
REQ-032 SHALL abandon an in-flight read or write on reset mid-operation, with no state surviving.

Structure
REQ-033 SHALL place register offsets, TIMER_CTRL bit indices and TXSTAT bit indices as constants in the shared package sys_periph_pkg.
REQ-034 SHALL implement the FIFO as sub-module sync_fifo, parameterised by width and depth, with count, full and empty outputs.
REQ-035 SHALL be usable as the responder to the CPU pipeline's sys_* bus, with no combinational path from sys_* inputs to sys_r_line.

Verification
REQ-036 SHALL cover reset and ID: a read of 0x00 gives 0x43505533; a read of 0x20 gives 0; a read of 0x1C gives 0; a read of 0x05 gives 0.
REQ-037 SHALL cover SCRATCH: a write of 0xDEADBEEF and a read of 0x04 in the same cycle returns the old value 0; the next read returns 0xDEADBEEF.
REQ-038 SHALL cover the timer: with CMP=5 and CTRL=3, the flag and irq rise on the cycle CNT==5, CNT then reads 0, and a write of 4 to CTRL clears irq.
REQ-039 SHALL cover the FIFO: 9 TXDATA writes with tx_ready=0 give TXSTAT=0xA8, the next TXSTAT read gives 0x28, and draining yields bytes 0..7 in order.
REQ-040 SHALL cover a simultaneous push and pop while full: count stays 8 and ovf stays 0.
REQ-041 SHALL cover reset mid-operation: asserting rst during a pending TXDATA write leaves the FIFO empty with tx_valid=0.
